// File: rtl/periph_arb_pkg.sv
// Shared types and helpers for the peripheral write arbiter.
// The arbiter serialises writes from several requesters onto one peripheral write port.
package periph_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Width of the wait counter; a disabled timeout (0) still needs one bit.
  function automatic int to_cnt_w(input int timeout_cyc);
    return (timeout_cyc < 1) ? 1 : $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: the first asserted request at or after ptr,
// wrapping modulo N_REQ.
module rr_priority_picker #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(N_REQ);

  // Scan from the farthest offset down so the nearest request to ptr is written last and wins.
  always_comb begin
    int s;
    valid = 1'b0;
    idx   = '0;
    s     = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      s = int'(ptr) + i;
      if (s >= N_REQ) s = s - N_REQ;
      if (req[s]) begin
        valid = 1'b1;
        idx   = IDX_W'(s);
      end
    end
  end

endmodule

// File: rtl/periph_wr_arbiter.sv
// Round-robin arbiter for the single peripheral write port: captures one requester,
// issues a one-cycle write strobe, waits for tgt_ready (with optional timeout), reports done/err.
//
// Handshake: req is a level held until that requester's done or err pulse; addr/data must
// stay stable while req is high. tgt_wr_en is a one-cycle strobe; the target accepts by
// raising tgt_ready in the strobe cycle or any later cycle before the timeout.
module periph_wr_arbiter
  import periph_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk_10MHz,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic [N_REQ-1:0]           err,
  output logic                       tgt_wr_en,
  output logic [ADDR_W-1:0]          tgt_addr,
  output logic [DATA_W-1:0]          tgt_wdata,
  input  logic                       tgt_ready,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [1:0]                 dbg_state
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = to_cnt_w(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);

  arb_state_e        state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt, id_nxt, pick_idx;
  logic              pick_valid;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_sat;
  logic [N_REQ-1:0]  gnt_nxt, done_nxt, err_nxt;
  logic              wr_en_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign cnt_sat   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    id_nxt    = grant_id;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    done_nxt  = '0;
    err_nxt   = '0;
    wr_en_nxt = 1'b0;
    addr_nxt  = tgt_addr;
    wdata_nxt = tgt_wdata;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          id_nxt            = pick_idx;
          addr_nxt          = req_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_nxt         = req_wdata[pick_idx*DATA_W +: DATA_W];
          gnt_nxt           = '0;
          gnt_nxt[pick_idx] = 1'b1;
          wr_en_nxt         = 1'b1;
          state_nxt         = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt = '0;
        if (tgt_ready) begin
          done_nxt[grant_id] = 1'b1;
          gnt_nxt            = '0;
          state_nxt          = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (tgt_ready) begin
          done_nxt[grant_id] = 1'b1;
          gnt_nxt            = '0;
          state_nxt          = DONE;
        end else begin
          cnt_nxt = cnt_sat;
          // A zero timeout never matches here, so the wait is unbounded.
          if ((TIMEOUT_CYC != 0) && (cnt_sat == TO_VAL)) begin
            err_nxt[grant_id] = 1'b1;
            gnt_nxt           = '0;
            state_nxt         = DONE;
          end
        end
      end
      DONE: begin
        ptr_nxt   = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_10MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      tgt_wr_en <= 1'b0;
      tgt_addr  <= '0;
      tgt_wdata <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_id  <= id_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      tgt_wr_en <= wr_en_nxt;
      tgt_addr  <= addr_nxt;
      tgt_wdata <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_periph_wr_arbiter.sv
// Testbench for periph_wr_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized phase checked against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_periph_wr_arbiter;

  localparam int N      = 2;
  localparam int AW     = 4;
  localparam int DW     = 32;
  localparam int TO     = 8;

  logic            clk_10MHz = 1'b0;
  logic            rst_n     = 1'b0;
  logic [N-1:0]    req       = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic            tgt_ready = 1'b0;
  logic [N-1:0]    gnt, done, err;
  logic            tgt_wr_en, busy;
  logic [AW-1:0]   tgt_addr;
  logic [DW-1:0]   tgt_wdata;
  logic [0:0]      grant_id;
  logic [1:0]      dbg_state;

  periph_wr_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_10MHz (clk_10MHz),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .tgt_wr_en (tgt_wr_en),
    .tgt_addr  (tgt_addr),
    .tgt_wdata (tgt_wdata),
    .tgt_ready (tgt_ready),
    .busy      (busy),
    .grant_id  (grant_id),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #50 clk_10MHz = ~clk_10MHz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_10MHz);
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic do_reset();
    req       = '0;
    tgt_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    int            delay;
    bit            drop;
    int            exp_id;
    bit            exp_err;
  } vec_t;

  vec_t vecs[8];

  // One transaction from IDLE: apply requests, target answers 'delay' cycles after the strobe.
  task automatic run_txn(input vec_t v);
    int cpl_k;
    req_addr  = {v.a1, v.a0};
    req_wdata = {v.d1, v.d0};
    req       = v.req;
    tgt_ready = 1'b0;
    step();
    check("wr_en_latency", tgt_wr_en, 1);
    check("grant_id", grant_id, v.exp_id);
    check("tgt_addr", tgt_addr, (v.exp_id == 1) ? v.a1 : v.a0);
    check("tgt_wdata", tgt_wdata, (v.exp_id == 1) ? v.d1 : v.d0);
    check("gnt_issue", gnt, oh(v.exp_id));
    if (v.drop) req = '0;
    cpl_k     = v.exp_err ? TO + 1 : v.delay + 1;
    tgt_ready = (v.delay == 0);
    for (int k = 1; k <= cpl_k; k++) begin
      step();
      if (k < cpl_k) begin
        check("gnt_hold", gnt, oh(v.exp_id));
        check("wr_en_once", tgt_wr_en, 0);
        check("no_early_cpl", {done, err}, 0);
      end else begin
        check("done", done, v.exp_err ? '0 : oh(v.exp_id));
        check("err", err, v.exp_err ? oh(v.exp_id) : '0);
        check("gnt_drop", gnt, 0);
      end
      tgt_ready = (k == v.delay);
    end
    req       = '0;
    tgt_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle_after", busy, 0);
      check("no_second_wr", {tgt_wr_en, done, err}, 0);
    end
  endtask

  // ---------------- scoreboard state ----------------
  logic [1:0]    exp_q[$];   // {is_err, id}
  int            cyc_q[$];   // cycle at which the completion pulse is due
  logic [AW-1:0] ra[N];
  logic [DW-1:0] rd[N];

  initial begin
    int            got[4];
    int            n_gnt, n_done;
    bit            active, cpl_now, exp_wr;
    int            m_ptr, m_id, wr_cycle, d, last_cpl, cpl_id, j;
    logic [1:0]    e;

    vecs[0] = '{2'b01, 4'h2, 32'h0000_0025, 4'h0, 32'h0,          0, 1'b0, 0, 1'b0};
    vecs[1] = '{2'b11, 4'h3, 32'h1111_1111, 4'h5, 32'hA5A5_A5A5,  0, 1'b0, 1, 1'b0};
    vecs[2] = '{2'b11, 4'h7, 32'hDEAD_BEEF, 4'h9, 32'h1234_5678,  3, 1'b0, 0, 1'b0};
    vecs[3] = '{2'b10, 4'h0, 32'h0,         4'hC, 32'h0F0F_0F0F,  5, 1'b0, 1, 1'b0};
    vecs[4] = '{2'b10, 4'h0, 32'h0,         4'hE, 32'hCAFE_0001,  9, 1'b0, 1, 1'b1};
    vecs[5] = '{2'b11, 4'h1, 32'h0000_0001, 4'h2, 32'h0000_0002,  8, 1'b0, 0, 1'b0};
    vecs[6] = '{2'b01, 4'hF, 32'hFFFF_FFFF, 4'h0, 32'h0,          3, 1'b1, 0, 1'b0};
    vecs[7] = '{2'b11, 4'h4, 32'h0000_0004, 4'hB, 32'h0000_B0B0,  1, 1'b0, 1, 1'b0};

    do_reset();
    check("reset_outputs", {gnt, done, err, tgt_wr_en, busy, grant_id, dbg_state}, 0);
    check("reset_tgt_bus", {tgt_addr, tgt_wdata}, 0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Contention: both requesters held high, target always ready.
    do_reset();
    req_addr  = {4'hA, 4'h5};
    req_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    req       = 2'b11;
    tgt_ready = 1'b1;
    n_gnt     = 0;
    n_done    = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (tgt_wr_en) begin
        if (n_gnt < 4) got[n_gnt] = int'(grant_id);
        n_gnt++;
      end
      n_done += $countones(done);
    end
    check("contention_done_count", n_done, 4);
    check("contention_grant_count", n_gnt, 4);
    for (int k = 0; k < 4; k++) check("contention_order", got[k], k % 2);
    req       = '0;
    tgt_ready = 1'b0;
    repeat (3) step();

    // Asynchronous reset in the middle of a WAIT; pointer must return to 0.
    vecs[0] = '{2'b01, 4'h6, 32'h0000_0066, 4'h0, 32'h0, 0, 1'b0, 0, 1'b0};
    run_txn(vecs[0]);
    req_addr  = {4'h8, 4'h6};
    req_wdata = {32'h0000_0088, 32'h0000_0066};
    req       = 2'b10;
    step();
    check("abort_txn_issue", {tgt_wr_en, grant_id}, 2'b11);
    repeat (3) step();
    check("abort_in_wait", busy, 1);
    #10 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {gnt, done, err, tgt_wr_en, busy, grant_id, dbg_state}, 0);
    check("async_reset_tgt_bus", {tgt_addr, tgt_wdata}, 0);
    req = '0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("no_pulse_after_reset", {done, err, busy, tgt_wr_en}, 0);
    end
    req       = 2'b11;
    tgt_ready = 1'b1;
    step();
    check("ptr_reset_grant", {tgt_wr_en, grant_id}, 2'b10);
    req = '0;
    repeat (3) step();
    tgt_ready = 1'b0;

    // Randomized phase against a transaction-level round-robin model.
    do_reset();
    active   = 1'b0;
    m_ptr    = 0;
    m_id     = 0;
    wr_cycle = 0;
    d        = 0;
    last_cpl = cyc - 2;
    exp_q.delete();
    cyc_q.delete();
    for (int t = 0; t < 1500; t++) begin
      step();
      cpl_now = 1'b0;
      cpl_id  = 0;
      // A capture happens after any IDLE cycle that saw a request; IDLE follows DONE.
      exp_wr = !active && ((cyc - 1) >= (last_cpl + 1)) && (req != '0);
      check("rnd_wr_en", tgt_wr_en, exp_wr);
      if (exp_wr) begin
        j = -1;
        for (int k = 0; k < N; k++)
          if (j < 0 && req[(m_ptr + k) % N]) j = (m_ptr + k) % N;
        m_id     = j;
        active   = 1'b1;
        wr_cycle = cyc;
        d        = int'($urandom_range(0, 10));
        exp_q.push_back({(d > TO) ? 1'b1 : 1'b0, 1'(j)});
        cyc_q.push_back((d > TO) ? cyc + TO + 1 : cyc + d + 1);
        check("rnd_grant_id", grant_id, j);
        check("rnd_tgt_addr", tgt_addr, ra[j]);
        check("rnd_tgt_wdata", tgt_wdata, rd[j]);
      end
      if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
        e = exp_q.pop_front();
        void'(cyc_q.pop_front());
        check("rnd_done", done, e[1] ? '0 : oh(int'(e[0])));
        check("rnd_err", err, e[1] ? oh(int'(e[0])) : '0);
        active   = 1'b0;
        last_cpl = cyc;
        cpl_now  = 1'b1;
        cpl_id   = int'(e[0]);
        m_ptr    = (cpl_id + 1) % N;
      end else begin
        check("rnd_no_pulse", {done, err}, 0);
      end
      check("rnd_gnt", gnt, active ? oh(m_id) : '0);
      check("rnd_busy", busy, active || cpl_now);

      for (int i = 0; i < N; i++) begin
        if (cpl_now && cpl_id == i) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          ra[i] = AW'($urandom);
          rd[i] = $urandom;
          req_addr[i*AW +: AW]  = ra[i];
          req_wdata[i*DW +: DW] = rd[i];
          req[i] = 1'b1;
        end
      end
      // Outside ISSUE/WAIT the target line is noise the arbiter must ignore.
      tgt_ready = active ? ((cyc - wr_cycle) == d) : 1'($urandom_range(0, 1));
    end
    check("rnd_queue_drained_or_pending", (exp_q.size() <= 1), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
